// File: rtl/uart_host_pkg.sv
// Shared types and default constants for the UART host controller.
package uart_host_pkg;

   // Controller FSM states
   typedef enum logic [2:0] {
      StIdle,
      StPoll,
      StStatus,
      StRdAddr,
      StRdData,
      StWrite
   } state_e;

   // Default UART register map
   localparam int unsigned DEF_ADDR_W     = 4;
   localparam logic [3:0]  DEF_ADDR_UDR   = 4'h0;
   localparam logic [3:0]  DEF_ADDR_UCSRA = 4'h1;

   // Default status bit positions inside UCSRA
   localparam int unsigned DEF_RXC_BIT  = 7;
   localparam int unsigned DEF_UDRE_BIT = 5;

endpackage

// File: rtl/uart_host_ctrl.sv
// Polls a memory-mapped UART, moving one held TX byte into UDR and one received
// byte out of UDR. Receive is serviced ahead of transmit to reduce overrun risk.
module uart_host_ctrl
   import uart_host_pkg::*;
#(
   parameter int unsigned       ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] ADDR_UDR   = ADDR_W'(DEF_ADDR_UDR),
   parameter logic [ADDR_W-1:0] ADDR_UCSRA = ADDR_W'(DEF_ADDR_UCSRA),
   parameter int unsigned       RXC_BIT    = DEF_RXC_BIT,
   parameter int unsigned       UDRE_BIT   = DEF_UDRE_BIT
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   // Host TX stream
   input  logic [7:0]        i_tx_data,
   input  logic              i_tx_valid,
   output logic              o_tx_ready,
   // Host RX stream
   output logic [7:0]        o_rx_data,
   output logic              o_rx_valid,
   input  logic              i_rx_ready,
   // UART register bus
   output logic              o_we,
   output logic [ADDR_W-1:0] o_address,
   output logic [7:0]        o_data,
   input  logic [7:0]        i_data
);

   localparam logic [2:0] RXC_IDX  = RXC_BIT[2:0];
   localparam logic [2:0] UDRE_IDX = UDRE_BIT[2:0];

   state_e            state_q;
   logic              tx_full_q;
   logic              rx_full_q;
   logic [7:0]        tx_buf_q;
   logic [7:0]        rx_data_q;
   logic              we_q;
   logic [ADDR_W-1:0] address_q;
   logic [7:0]        data_q;

   logic status_rxc;
   logic status_udre;

   // Status bits as returned by the UCSRA read; only meaningful in StStatus
   always_comb begin
      status_rxc  = i_data[RXC_IDX];
      status_udre = i_data[UDRE_IDX];
   end

   // FSM, holding registers and bus outputs; bus outputs are registered so they
   // are loaded with the values belonging to the state being entered.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= StIdle;
         tx_full_q <= 1'b0;
         rx_full_q <= 1'b0;
         tx_buf_q  <= 8'h00;
         rx_data_q <= 8'h00;
         we_q      <= 1'b0;
         address_q <= ADDR_UCSRA;
         data_q    <= 8'h00;
      end else begin
         // Host-side handshakes; accept cannot collide with StWrite since
         // tx_full_q is set there, and release cannot collide with capture
         // since a read only starts while rx_full_q is clear.
         if (i_tx_valid && !tx_full_q) begin
            tx_buf_q  <= i_tx_data;
            tx_full_q <= 1'b1;
         end
         if (rx_full_q && i_rx_ready) begin
            rx_full_q <= 1'b0;
         end

         // Bus defaults: status address, no write, zero data
         we_q      <= 1'b0;
         address_q <= ADDR_UCSRA;
         data_q    <= 8'h00;

         case (state_q)
            StIdle: begin
               state_q <= StPoll;
            end
            StPoll: begin
               state_q <= StStatus;
            end
            StStatus: begin
               if (status_rxc && !rx_full_q) begin
                  state_q   <= StRdAddr;
                  address_q <= ADDR_UDR;
               end else if (status_udre && tx_full_q) begin
                  state_q   <= StWrite;
                  we_q      <= 1'b1;
                  address_q <= ADDR_UDR;
                  data_q    <= tx_buf_q;
               end else begin
                  state_q <= StPoll;
               end
            end
            StRdAddr: begin
               state_q   <= StRdData;
               address_q <= ADDR_UDR;
            end
            StRdData: begin
               rx_data_q <= i_data;
               rx_full_q <= 1'b1;
               state_q   <= StPoll;
            end
            StWrite: begin
               tx_full_q <= 1'b0;
               state_q   <= StPoll;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Output mapping from the registered state
   always_comb begin
      o_tx_ready = ~tx_full_q;
      o_rx_valid = rx_full_q;
      o_rx_data  = rx_data_q;
      o_we       = we_q;
      o_address  = address_q;
      o_data     = data_q;
   end

endmodule
